// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running H/V counters with registered sync and status strobes.
// Define SYNC_DELAY_EN to delay HSync/VSync by SYNC_DELAY clocks behind the counters.
module vga_timing_gen #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int SYNC_DELAY     = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  output logic [9:0] o_H_Counter,
  output logic [9:0] o_V_Counter,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Visible,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
);

  localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE_AREA);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE_AREA);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE - 1);

`ifdef SYNC_DELAY_EN
  localparam int PIPE_DEPTH = SYNC_DELAY;
`else
  localparam int PIPE_DEPTH = 0;
`endif

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       visible_q, visible_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Status is decoded from the next counter values so it lands in the same cycle as the counters.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    hsync_d       = !((h_d >= H_SYNC_FIRST) && (h_d <= H_SYNC_LAST));
    vsync_d       = !((v_d >= V_SYNC_FIRST) && (v_d <= V_SYNC_LAST));
    visible_d     = (h_d < H_VIS) && (v_d < V_VIS);
    line_start_d  = (h_d == '0);
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_H_Counter   = h_q;
  assign o_V_Counter   = v_q;
  assign o_Visible     = visible_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;

  generate
    if (PIPE_DEPTH > 0) begin : g_sync_delay
      logic [PIPE_DEPTH-1:0] hsync_pipe_q, hsync_pipe_d;
      logic [PIPE_DEPTH-1:0] vsync_pipe_q, vsync_pipe_d;

      // Bit 0 takes the aligned sync; the top bit is the delayed output.
      always_comb begin
        hsync_pipe_d = (hsync_pipe_q << 1) | PIPE_DEPTH'(hsync_q);
        vsync_pipe_d = (vsync_pipe_q << 1) | PIPE_DEPTH'(vsync_q);
      end

      always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
          hsync_pipe_q <= '1;
          vsync_pipe_q <= '1;
        end else begin
          hsync_pipe_q <= hsync_pipe_d;
          vsync_pipe_q <= vsync_pipe_d;
        end
      end

      assign o_HSync = hsync_pipe_q[PIPE_DEPTH-1];
      assign o_VSync = vsync_pipe_q[PIPE_DEPTH-1];
    end else begin : g_sync_direct
      assign o_HSync = hsync_q;
      assign o_VSync = vsync_q;
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE_AREA, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, pixels between visible area and HSync.
REQ-003 SHALL have parameter H_SYNC_PULSE, default 96, HSync width in pixels.
REQ-004 SHALL have parameter H_BACK_PORCH, default 48, pixels between HSync and next line.
REQ-005 SHALL have parameter V_VISIBLE_AREA, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT_PORCH, default 10, lines between visible area and VSync.
REQ-007 SHALL have parameter V_SYNC_PULSE, default 2, VSync width in lines.
REQ-008 SHALL have parameter V_BACK_PORCH, default 33, lines between VSync and next frame.
REQ-009 SHALL have parameter SYNC_DELAY, default 2, sync pipeline depth used only when SYNC_DELAY_EN is defined.
REQ-010 SHALL have port i_Clk  input  1  pixel clock (25 MHz); all logic on its rising edge.
REQ-011 SHALL have port i_Rst_n  input  1  synchronous, active-low reset.
REQ-012 SHALL have port o_H_Counter  output  10  horizontal position, 0..H_TOTAL-1.
REQ-013 SHALL have port o_V_Counter  output  10  vertical position, 0..V_TOTAL-1.
REQ-014 SHALL have port o_HSync  output  1  horizontal sync, active low.
REQ-015 SHALL have port o_VSync  output  1  vertical sync, active low.
REQ-016 SHALL have port o_Visible  output  1  high when the counters are inside the visible area.
REQ-017 SHALL have port o_Line_Start  output  1  one-cycle pulse when o_H_Counter==0.
REQ-018 SHALL have port o_Frame_Start  output  1  one-cycle pulse when both counters are 0.

Function
REQ-019 SHALL define H_TOTAL as the sum of the four H parameters (800) and V_TOTAL as the sum of the four V parameters (525).
REQ-020 SHALL increment o_H_Counter by 1 every clock, wrapping from H_TOTAL-1 to 0.
REQ-021 SHALL increment o_V_Counter only on the cycle o_H_Counter wraps, wrapping from V_TOTAL-1 to 0 when both counters wrap together.
REQ-022 SHALL register all status outputs and align them with the counter values presented in the same cycle, with zero relative latency.
REQ-023 SHALL drive o_HSync low iff o_H_Counter lies in [H_VISIBLE_AREA+H_FRONT_PORCH, H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE-1], which is [656,751] by default.
REQ-024 SHALL drive o_VSync low iff o_V_Counter lies in [V_VISIBLE_AREA+V_FRONT_PORCH, V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE-1], which is [490,491] by default.
REQ-025 SHALL drive o_Visible high iff o_H_Counter<H_VISIBLE_AREA and o_V_Counter<V_VISIBLE_AREA.
REQ-026 SHALL pulse o_Line_Start on every line and o_Frame_Start exactly once per V_TOTAL*H_TOTAL cycles (420000 by default).
REQ-027 SHALL keep the counters in range with no intermediate out-of-range value, including when both counters wrap simultaneously.

Reset
REQ-028 SHALL, on any clock edge with i_Rst_n low (including mid-frame), load the counters to H_TOTAL-1 and V_TOTAL-1 (799, 524).
REQ-029 SHALL, in the same reset condition, drive o_HSync=1, o_VSync=1, o_Visible=0, o_Line_Start=0 and o_Frame_Start=0, and load any sync delay stages with 1.
REQ-030 SHALL present counters (0,0) with o_Frame_Start=1, o_Line_Start=1 and o_Visible=1 on the first edge after i_Rst_n goes high.

Configuration
REQ-031 SHALL, when macro SYNC_DELAY_EN is defined, delay o_HSync and o_VSync by SYNC_DELAY cycles relative to the counters and the other status outputs, so sync stays aligned with downstream pixel pipeline latency.
REQ-032 SHALL, when SYNC_DELAY_EN is undefined, omit the delay registers and keep o_HSync and o_VSync cycle-aligned with the counters.

Verification
REQ-033 SHALL cover: release reset -> next cycle H=0, V=0, Frame_Start=1, Line_Start=1, Visible=1, HSync=1, VSync=1.
REQ-034 SHALL cover: free run over one line -> HSync=1 at H=655, 0 at H=656 and H=751, 1 at H=752; Visible=0 from H=640.
REQ-035 SHALL cover: H=799, V=10 -> next cycle H=0, V=11, Line_Start=1, Frame_Start=0.
REQ-036 SHALL cover: H=799, V=524 -> next cycle H=0, V=0, Frame_Start=1; exactly one Frame_Start every 420000 cycles over 3 frames.
REQ-037 SHALL cover: reset asserted at H=300, V=200 for 1 cycle -> counters 799/524 and syncs high, then (0,0) on the next edge.
REQ-038 SHALL cover: SYNC_DELAY_EN defined with SYNC_DELAY=2 -> HSync low from H=658 to H=753 and VSync low during lines 490-491, lagging by 2 clocks.
